// File: rtl/pwm_sweep_gen.sv
// Multi-channel PWM on one shared period counter; each channel runs a fixed duty or a shared triangle sweep.
// Latency: one clock from counter compare to PWM pin. No backpressure: free-running while enable is high.
module pwm_sweep_gen #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 20,
  parameter int PERIOD     = 1000000,
  parameter int SWEEP_STEP = 10000
) (
  input  logic                      clk_100MHz,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [CHANNELS-1:0]       mode,
  input  logic [CHANNELS*CNT_W-1:0] duty_in,
  input  logic                      duty_load,
  output logic [CHANNELS-1:0]       PWM,
  output logic                      period_tick,
  output logic                      sweep_dir
);

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] PERIOD_N   = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] STEP_N     = CNT_W'(SWEEP_STEP);
  localparam logic [CNT_W:0]   PERIOD_EXT = (CNT_W+1)'(PERIOD);
  localparam logic [CNT_W:0]   STEP_EXT   = (CNT_W+1)'(SWEEP_STEP);

  typedef logic [CHANNELS-1:0][CNT_W-1:0] duty_vec_t;

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  duty_vec_t           pend_q, pend_d;
  duty_vec_t           act_q, act_d;
  duty_vec_t           duty_words;
  duty_vec_t           eff_duty;
  logic [CNT_W-1:0]    sweep_q, sweep_d;
  logic                sweep_dir_q, sweep_dir_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                tick_q, tick_d;
  logic                wrap;
  logic [CNT_W:0]      sweep_up;

  assign duty_words = duty_in;
  assign wrap       = enable && (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = '0;
    if (enable) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // Rising sum is one bit wider so the top of the sweep cannot wrap around.
  assign sweep_up = {1'b0, sweep_q} + STEP_EXT;

  always_comb begin
    sweep_d     = sweep_q;
    sweep_dir_d = sweep_dir_q;
    if (wrap) begin
      if (sweep_dir_q) begin
        if (sweep_up >= PERIOD_EXT) begin
          sweep_d     = PERIOD_N;
          sweep_dir_d = 1'b0;
        end else begin
          sweep_d = sweep_up[CNT_W-1:0];
        end
      end else begin
        if ({1'b0, sweep_q} <= STEP_EXT) begin
          sweep_d     = '0;
          sweep_dir_d = 1'b1;
        end else begin
          sweep_d = sweep_q - STEP_N;
        end
      end
    end
  end

  // Active words shadow the pending ones: parked counter tracks them, a running one only swaps at wrap.
  always_comb begin
    pend_d = duty_load ? duty_words : pend_q;
    act_d  = act_q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!enable) begin
        act_d[i] = pend_q[i];
      end else if (wrap && duty_load) begin
        act_d[i] = duty_words[i];
      end else if (wrap && !mode[i]) begin
        act_d[i] = pend_q[i];
      end
    end
  end

  always_comb begin
    eff_duty = act_q;
    pwm_d    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (mode[i]) begin
        eff_duty[i] = sweep_q;
      end
      pwm_d[i] = enable && (cnt_q < eff_duty[i]);
    end
  end

  assign tick_d = wrap;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      pend_q      <= '0;
      act_q       <= '0;
      sweep_q     <= '0;
      sweep_dir_q <= 1'b1;
      pwm_q       <= '0;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
      sweep_q     <= sweep_d;
      sweep_dir_q <= sweep_dir_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
    end
  end

  assign PWM         = pwm_q;
  assign period_tick = tick_q;
  assign sweep_dir   = sweep_dir_q;

endmodule

// File: tb/tb_pwm_sweep_gen.sv
// Bench for pwm_sweep_gen at CHANNELS=2, CNT_W=4, PERIOD=10, SWEEP_STEP=3.
// Directed scenarios plus a randomized run against a cycle-level reference model.
module tb_pwm_sweep_gen;

  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int P    = 10;
  localparam int STEP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [CH-1:0] mode;
  logic [CH*W-1:0] duty;
  logic          load;
  logic [CH-1:0] PWM;
  logic          period_tick;
  logic          sweep_dir;

  int total  = 0;
  int passed = 0;

  int m_cnt;
  int m_pend[CH];
  int m_act[CH];
  int m_sweep;
  bit m_dir;
  bit [CH-1:0] m_pwm;
  bit m_tick;

  pwm_sweep_gen #(
    .CHANNELS(CH), .CNT_W(W), .PERIOD(P), .SWEEP_STEP(STEP)
  ) dut (
    .clk_100MHz (clk),
    .rst_n      (rst_n),
    .enable     (en),
    .mode       (mode),
    .duty_in    (duty),
    .duty_load  (load),
    .PWM        (PWM),
    .period_tick(period_tick),
    .sweep_dir  (sweep_dir)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_cnt = 0; m_sweep = 0; m_dir = 1'b1; m_pwm = '0; m_tick = 1'b0;
    for (int c = 0; c < CH; c++) begin
      m_pend[c] = 0;
      m_act[c]  = 0;
    end
  endtask

  // One rising edge of the specified behaviour, using the inputs present before the edge.
  task automatic model_edge();
    bit wrap;
    int eff;
    int d;
    wrap = en && (m_cnt == P - 1);
    for (int c = 0; c < CH; c++) begin
      eff = mode[c] ? m_sweep : m_act[c];
      m_pwm[c] = en && (m_cnt < eff);
    end
    m_tick = wrap;
    if (wrap) begin
      if (m_dir) begin
        if (m_sweep + STEP >= P) begin m_sweep = P; m_dir = 1'b0; end
        else m_sweep = m_sweep + STEP;
      end else begin
        if (m_sweep <= STEP) begin m_sweep = 0; m_dir = 1'b1; end
        else m_sweep = m_sweep - STEP;
      end
    end
    for (int c = 0; c < CH; c++) begin
      d = int'((duty >> (c * W)) & 8'h0f);
      if (!en) m_act[c] = m_pend[c];
      else if (wrap && load) m_act[c] = d;
      else if (wrap && !mode[c]) m_act[c] = m_pend[c];
      if (load) m_pend[c] = d;
    end
    m_cnt = en ? (wrap ? 0 : m_cnt + 1) : 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  // Runs one full period from count 0, optionally pulsing duty_load before edge load_k.
  task automatic run_period(input int load_k, input logic [CH*W-1:0] load_val,
                            output int o0, output int o1, output int tk, output logic dir_mid);
    int g;
    g = 0;
    while (m_cnt != 0 && g < 20) begin tick(); g++; end
    o0 = 0; o1 = 0; tk = 0; dir_mid = 1'b0;
    for (int k = 0; k < P; k++) begin
      if (k == load_k) begin duty = load_val; load = 1'b1; end
      tick();
      load = 1'b0;
      o0 += int'(PWM[0]);
      o1 += int'(PWM[1]);
      tk += int'(period_tick);
      if (k == 4) dir_mid = sweep_dir;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; en = 1'b0; mode = '0; duty = '0; load = 1'b0;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (PWM !== 2'b00) $display("FAIL reset_pwm: got %b want 00", PWM); else passed++;
    total++; if (period_tick !== 1'b0) $display("FAIL reset_tick: got %b want 0", period_tick); else passed++;
    total++; if (sweep_dir !== 1'b1) $display("FAIL reset_dir: got %b want 1", sweep_dir); else passed++;
    en = 1'b1; mode = 2'b11; duty = 8'hff; load = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++; if (PWM !== 2'b00 || period_tick !== 1'b0)
        $display("FAIL reset_hold: got pwm=%b tick=%b want 00/0", PWM, period_tick); else passed++;
    end
    en = 1'b0; mode = '0; duty = '0; load = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_fixed();
    int ones0, ones1, ticks;
    en = 1'b0; mode = 2'b00; duty = {4'd7, 4'd3}; load = 1'b1;
    tick(); load = 1'b0; tick(); tick();
    en = 1'b1;
    ones0 = 0; ones1 = 0; ticks = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      total++; if (PWM !== m_pwm || period_tick !== m_tick)
        $display("FAIL fixed_model cyc %0d: got pwm=%b tick=%b want %b/%b", k, PWM, period_tick, m_pwm, m_tick);
      else passed++;
      if (k == 1) begin
        total++; if (PWM !== 2'b11) $display("FAIL fixed_first: got %b want 11", PWM); else passed++;
      end
      if (k == 4) begin
        total++; if (PWM !== 2'b10) $display("FAIL fixed_lag: got %b want 10", PWM); else passed++;
      end
      ones0 += int'(PWM[0]); ones1 += int'(PWM[1]); ticks += int'(period_tick);
    end
    total++; if (ones0 != 9) $display("FAIL fixed_ch0_high: got %0d want 9", ones0); else passed++;
    total++; if (ones1 != 21) $display("FAIL fixed_ch1_high: got %0d want 21", ones1); else passed++;
    total++; if (ticks != 3) $display("FAIL fixed_ticks: got %0d want 3", ticks); else passed++;
  endtask

  task automatic test_shadow_and_bounds();
    int o0, o1, tk;
    logic dm;
    run_period(4, {4'd7, 4'd5}, o0, o1, tk, dm);
    total++; if (o0 != 3) $display("FAIL shadow_mid_load_current: got %0d want 3", o0); else passed++;
    run_period(-1, '0, o0, o1, tk, dm);
    total++; if (o0 != 5) $display("FAIL shadow_mid_load_next: got %0d want 5", o0); else passed++;
    run_period(9, {4'd7, 4'd6}, o0, o1, tk, dm);
    total++; if (o0 != 5) $display("FAIL shadow_wrap_load_current: got %0d want 5", o0); else passed++;
    run_period(9, {4'd10, 4'd0}, o0, o1, tk, dm);
    total++; if (o0 != 6) $display("FAIL shadow_wrap_load_next: got %0d want 6", o0); else passed++;
    run_period(9, {4'd15, 4'd0}, o0, o1, tk, dm);
    total++; if (o0 != 0) $display("FAIL bound_duty0: got %0d want 0", o0); else passed++;
    total++; if (o1 != 10) $display("FAIL bound_duty10: got %0d want 10", o1); else passed++;
    for (int p = 0; p < 2; p++) begin
      run_period(-1, '0, o0, o1, tk, dm);
      total++; if (o1 != 10 || o0 != 0)
        $display("FAIL bound_duty15 period %0d: got high %0d/%0d want 0/10", p, o0, o1); else passed++;
      total++; if (tk != 1) $display("FAIL bound_tick period %0d: got %0d want 1", p, tk); else passed++;
    end
  endtask

  task automatic test_sweep();
    int exp_hi[10] = '{0, 3, 6, 9, 10, 7, 4, 1, 0, 3};
    bit exp_dir[10] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
    int o0, o1, tk;
    logic dm;
    #2 rst_n = 1'b0;
    model_reset();
    tick();
    rst_n = 1'b1; en = 1'b1; mode = 2'b11; duty = '0; load = 1'b0;
    for (int p = 0; p < 10; p++) begin
      run_period(-1, '0, o0, o1, tk, dm);
      total++; if (o0 != exp_hi[p] || o1 != exp_hi[p])
        $display("FAIL sweep_high period %0d: got %0d/%0d want %0d", p, o0, o1, exp_hi[p]); else passed++;
      total++; if (dm !== exp_dir[p])
        $display("FAIL sweep_dir period %0d: got %b want %b", p, dm, exp_dir[p]); else passed++;
    end
  endtask

  task automatic test_disrupt();
    int g, o0, o1, tk;
    logic dm;
    g = 0;
    while (m_cnt != 6 && g < 20) begin tick(); g++; end
    en = 1'b0;
    tick();
    total++; if (PWM !== 2'b00 || period_tick !== 1'b0)
      $display("FAIL disable_pwm: got pwm=%b tick=%b want 00/0", PWM, period_tick); else passed++;
    repeat (4) tick();
    total++; if (sweep_dir !== 1'b1) $display("FAIL disable_dir: got %b want 1", sweep_dir); else passed++;
    en = 1'b1;
    run_period(-1, '0, o0, o1, tk, dm);
    total++; if (o0 != 6 || o1 != 6)
      $display("FAIL reenable_frozen_sweep: got %0d/%0d want 6", o0, o1); else passed++;
    total++; if (tk != 1) $display("FAIL reenable_tick: got %0d want 1", tk); else passed++;
    repeat (3) tick();
    #2;
    total++; if (PWM !== 2'b11) $display("FAIL pre_reset_pwm: got %b want 11", PWM); else passed++;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++; if (PWM !== 2'b00 || period_tick !== 1'b0 || sweep_dir !== 1'b1)
      $display("FAIL midreset: got pwm=%b tick=%b dir=%b want 00/0/1", PWM, period_tick, sweep_dir); else passed++;
    tick();
    rst_n = 1'b1; mode = 2'b00;
    run_period(-1, '0, o0, o1, tk, dm);
    total++; if (o0 != 0 || o1 != 0)
      $display("FAIL post_reset_duties: got %0d/%0d want 0/0", o0, o1); else passed++;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      en   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 7) == 0) mode = CH'($urandom_range(0, 3));
      load = ($urandom_range(0, 5) == 0);
      duty = (CH*W)'($urandom_range(0, 255));
      tick();
      total++; if (PWM !== m_pwm)
        $display("FAIL rand_pwm cyc %0d: got %b want %b", k, PWM, m_pwm); else passed++;
      total++; if (period_tick !== m_tick)
        $display("FAIL rand_tick cyc %0d: got %b want %b", k, period_tick, m_tick); else passed++;
      total++; if (sweep_dir !== m_dir)
        $display("FAIL rand_dir cyc %0d: got %b want %b", k, sweep_dir, m_dir); else passed++;
    end
    load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_shadow_and_bounds();
    test_sweep();
    test_disrupt();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
